// File: rtl/gnr_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// gnr_cycle_ctrl -- run controller for cycle detection on a gene-regulatory
// network (GRN). A tortoise (s0) and a hare (s1) copy of the network are
// stepped together. The run stops when their states match or when the step
// limit is reached, and the outcome is then reported.
//
// Optional build macro: GNR_CTRL_PERF_EN adds a run cycle counter. When it is
// undefined, res_cycles is tied to 0.
//
// Ports
//   clk, rst            sole clock; synchronous active-high reset
//   start               run enable; while low, no step is issued
//   init_valid/ready    initial-state handshake (ready only in IDLE)
//   init_data           initial network state
//   reset_nos           one-cycle node load pulse, with init_state
//   init_state          per-node load value (bit i -> node i)
//   start_s0/start_s1   tortoise/hare step pulses (always issued together)
//   s0_vec/s1_vec       node outputs, compared in CMP
//   res_valid/ready     result handshake
//   res_state           s1_vec captured when the run ends
//   res_steps           number of step pulses issued in this run
//   res_timeout         run ended at MAX_STEPS without a match
//   res_cycles          LOAD+STEP+CMP cycles of the run (perf build only)
// ---------------------------------------------------------------------------
module gnr_cycle_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               init_valid,
    output logic               init_ready,
    input  logic [N_NODES-1:0] init_data,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_state,
    output logic [CNT_W-1:0]   res_steps,
    output logic               res_timeout,
    output logic [31:0]        res_cycles
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_STEPS);

    typedef enum logic [2:0] {IDLE, LOAD, STEP, CMP, RESULT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_reset_nos;
    logic [N_NODES-1:0] r_init_state;
    logic               r_step_pulse;
    logic [CNT_W-1:0]   r_steps;
    logic [N_NODES-1:0] r_res_state;
    logic               r_res_timeout;
    logic               w_accept;
    logic               w_match;
    logic               w_done;

    assign init_ready = (r_state == IDLE) && start && !rst;
    assign w_accept   = init_ready && init_valid;
    assign w_match    = (s0_vec == s1_vec);
    assign w_done     = (r_state == CMP) && (w_match || (r_steps == LP_MAX));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = LOAD;
            LOAD:    w_next = STEP;
            // The step pulse is already on the wire during this cycle, so the
            // nodes advance on the edge that leaves STEP.
            STEP:    if (r_step_pulse) w_next = CMP;
            CMP:     w_next = w_done ? RESULT : STEP;
            RESULT:  if (res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_reset_nos   <= 1'b0;
            r_init_state  <= '0;
            r_step_pulse  <= 1'b0;
            r_steps       <= '0;
            r_res_state   <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_reset_nos  <= (w_next == LOAD);
            r_init_state <= w_accept ? init_data : '0;
            // Pulses are registered outputs, so start is sampled on the edge
            // that enters (or stays in) STEP. A low sample gives a paused STEP.
            r_step_pulse <= (w_next == STEP) && start;
            if (w_accept)
                r_steps <= '0;
            else if ((r_state == STEP) && r_step_pulse && (r_steps != LP_MAX))
                r_steps <= r_steps + 1'b1;
            if (w_done) begin
                r_res_state   <= s1_vec;
                // A match wins over the step limit.
                r_res_timeout <= !w_match;
            end
        end
    end

    assign reset_nos   = r_reset_nos;
    assign init_state  = r_init_state;
    assign start_s0    = r_step_pulse;
    assign start_s1    = r_step_pulse;
    assign res_valid   = (r_state == RESULT);
    assign res_state   = r_res_state;
    assign res_steps   = r_steps;
    assign res_timeout = r_res_timeout;

`ifdef GNR_CTRL_PERF_EN
    logic [31:0] r_cyc;
    logic [31:0] r_res_cycles;
    logic [31:0] w_cyc_inc;
    logic        w_busy;

    assign w_busy    = (r_state == LOAD) || (r_state == STEP) || (r_state == CMP);
    assign w_cyc_inc = (r_cyc == '1) ? r_cyc : r_cyc + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc        <= '0;
            r_res_cycles <= '0;
        end else begin
            if (w_accept)
                r_cyc <= '0;
            else if (w_busy)
                r_cyc <= w_cyc_inc;
            // The final CMP cycle is included in the latched value.
            if (w_done)
                r_res_cycles <= w_cyc_inc;
        end
    end

    assign res_cycles = r_res_cycles;
`else
    assign res_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
module tb_gnr_cycle_ctrl;
    localparam int N  = 4;
    localparam int CW = 16;
    localparam int MX = 8;
`ifdef GNR_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b1;
    logic          init_valid = 1'b0;
    logic          res_ready = 1'b1;
    logic [N-1:0]  init_data = '0;
    logic          init_ready, reset_nos, start_s0, start_s1, res_valid, res_timeout;
    logic [N-1:0]  init_state, s0_vec, s1_vec, res_state;
    logic [CW-1:0] res_steps;
    logic [31:0]   res_cycles;

    gnr_cycle_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MX)) dut (
        .clk(clk), .rst(rst), .start(start),
        .init_valid(init_valid), .init_ready(init_ready), .init_data(init_data),
        .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1),
        .s0_vec(s0_vec), .s1_vec(s1_vec),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_state(res_state), .res_steps(res_steps),
        .res_timeout(res_timeout), .res_cycles(res_cycles)
    );

    always #5 clk = ~clk;

    // Node model: mode 0 = identity network (tortoise and hare always agree),
    // mode 1 = +1 network with a double-speed hare, which never meets the
    // tortoise within 8 steps. The tortoise moves on odd-numbered pulses.
    logic         mode = 1'b0;
    logic [N-1:0] m_s0 = '0, m_s1 = '0;
    int           m_cnt = 0;
    int           n_s1 = 0;
    int           n_rn = 0;
    assign s0_vec = m_s0;
    assign s1_vec = m_s1;

    always @(posedge clk) begin
        if (reset_nos) begin
            m_s0  <= init_state;
            m_s1  <= init_state;
            m_cnt <= 0;
            n_rn  <= n_rn + 1;
        end else if (start_s0) begin
            m_s1  <= mode ? m_s1 + 4'd2 : m_s1;
            if (m_cnt % 2 == 0) m_s0 <= mode ? m_s0 + 4'd1 : m_s0;
            m_cnt <= m_cnt + 1;
        end
        if (start_s1) n_s1 <= n_s1 + 1;
    end

    typedef struct {
        logic [N-1:0]  st;
        logic [CW-1:0] steps;
        logic          to;
        logic [31:0]   cyc;
    } res_t;
    res_t sb[$];
    res_t cur;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] st, input int steps, input logic to, input int cyc);
        res_t e;
        e.st = st; e.steps = CW'(steps); e.to = to; e.cyc = PERF ? 32'(cyc) : 32'd0;
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_init_ready"}, 32'(init_ready), 0);
        chk({tag, "_pulses"}, {29'd0, reset_nos, start_s0, start_s1}, 0);
        chk({tag, "_init_state"}, 32'(init_state), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_res_state"}, 32'(res_state), 0);
        chk({tag, "_res_steps"}, 32'(res_steps), 0);
        chk({tag, "_res_timeout"}, 32'(res_timeout), 0);
        chk({tag, "_res_cycles"}, res_cycles, 0);
    endtask

    // Offer init_data and return at the negedge of the LOAD cycle.
    task automatic launch(input logic m, input logic [N-1:0] d);
        mode = m;
        @(negedge clk);
        chk("idle_ready", 32'(init_ready), 1);
        init_valid = 1'b1;
        init_data  = d;
        @(negedge clk);
        init_valid = 1'b0;
        chk("load_pulse", 32'(reset_nos), 1);
        chk("load_value", 32'(init_state), 32'(d));
        chk("load_not_ready", 32'(init_ready), 0);
    endtask

    task automatic wait_res(output int lat);
        lat = 1;
        for (int i = 0; i < 200 && !res_valid; i++) begin
            @(negedge clk);
            lat++;
        end
        chk("res_valid_seen", 32'(res_valid), 1);
    endtask

    task automatic cmp_res(input string tag);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            cur = sb.pop_front();
            chk({tag, "_state"}, 32'(res_state), 32'(cur.st));
            chk({tag, "_steps"}, 32'(res_steps), 32'(cur.steps));
            chk({tag, "_timeout"}, 32'(res_timeout), 32'(cur.to));
            chk({tag, "_cycles"}, res_cycles, cur.cyc);
        end
    endtask

    initial begin
        int lat, rn0, s10, seen;
        logic [CW-1:0] frz;

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready_start", 32'(init_ready), 1);
        start = 1'b0;
        @(negedge clk);
        chk("idle_ready_nostart", 32'(init_ready), 0);
        start = 1'b1;

        // Identity network: first-step match
        rn0 = n_rn; s10 = n_s1;
        push_exp(4'b1010, 1, 1'b0, 3);
        launch(1'b0, 4'b1010);
        wait_res(lat);
        chk("id_latency", 32'(lat), 4);
        cmp_res("id");
        chk("id_load_pulses", 32'(n_rn - rn0), 1);
        chk("id_step_pulses", 32'(n_s1 - s10), 1);
        @(negedge clk);
        chk("id_released", 32'(res_valid), 0);

        // Never-matching network: timeout, with res_ready held low 5 cycles
        s10 = n_s1;
        res_ready = 1'b0;
        push_exp(4'(4'b0011 + 2 * MX), MX, 1'b1, 1 + 2 * MX);
        launch(1'b1, 4'b0011);
        wait_res(lat);
        cmp_res("to");
        chk("to_step_pulses", 32'(n_s1 - s10), MX);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_state", 32'(res_state), 32'(cur.st));
            chk("hold_steps", 32'(res_steps), 32'(cur.steps));
            chk("hold_timeout", 32'(res_timeout), 32'(cur.to));
            chk("hold_cycles", res_cycles, cur.cyc);
            chk("hold_not_ready", 32'(init_ready), 0);
            chk("hold_no_pulse", {30'd0, reset_nos, start_s0}, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("to_released", 32'(res_valid), 0);

        // Pause: start low for 3 cycles mid-run adds 3 STEP cycles
        s10 = n_s1;
        push_exp(4'(4'b0101 + 2 * MX), MX, 1'b1, 1 + 2 * MX + 3);
        launch(1'b1, 4'b0101);
        seen = 0;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            @(negedge clk);
            if (start_s0) seen++;
        end
        chk("pause_reach", 32'(seen), 2);
        @(negedge clk);
        start = 1'b0;
        frz = res_steps;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pause_no_pulse", {30'd0, start_s0, start_s1}, 0);
            chk("pause_frozen", 32'(res_steps), 32'(frz));
        end
        start = 1'b1;
        wait_res(lat);
        cmp_res("pause");
        chk("pause_step_pulses", 32'(n_s1 - s10), MX);
        @(negedge clk);

        // Reset during CMP of step 2: run aborted, no result
        launch(1'b1, 4'b0001);
        seen = 0;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            @(negedge clk);
            if (start_s0) seen++;
        end
        @(negedge clk);
        chk("abort_in_cmp2", 32'(res_steps), 2);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(res_valid), 0);
            chk("abort_idle", 32'(init_ready), 1);
        end

        // Recovery: identity run after the abort
        push_exp(4'b0110, 1, 1'b0, 3);
        launch(1'b0, 4'b0110);
        wait_res(lat);
        chk("rec_latency", 32'(lat), 4);
        cmp_res("rec");
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
